// File: rtl/tb_ram_arbiter_pkg.sv
// Shared types for the testbench-subsystem RAM arbiter: port encoding and
// counter width.
package tb_ram_arbiter_pkg;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_sel_e;

  localparam int unsigned CONFLICT_CNT_WIDTH = 32;

endpackage

// File: rtl/tb_ram_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Bit 0 is the instruction port and bit 1 is
// the data port. When both request, the port not granted last time wins.
module rr_arb2
  import tb_ram_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output port_sel_e  last_o
);

  port_sel_e last_q;
  port_sel_e last_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= PORT_DATA;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (req[0] && (!req[1] || last_q == PORT_DATA)) begin
      gnt[0] = 1'b1;
      last_d = PORT_INSTR;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
      last_d = PORT_DATA;
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/tb_ram_arbiter.sv
// Shares one single-port RAM between the instruction-fetch and data ports.
// It grants one request per cycle and returns each response to the port that issued it.
module tb_ram_arbiter
  import tb_ram_arbiter_pkg::*;
#(
  parameter int unsigned RAM_ADDR_WIDTH = 22,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          instr_req_i,
  input  logic [31:0]                   instr_addr_i,
  output logic                          instr_gnt_o,
  output logic                          instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]         instr_rdata_o,
  input  logic                          data_req_i,
  input  logic                          data_we_i,
  input  logic [DATA_WIDTH/8-1:0]       data_be_i,
  input  logic [31:0]                   data_addr_i,
  input  logic [DATA_WIDTH-1:0]         data_wdata_i,
  output logic                          data_gnt_o,
  output logic                          data_rvalid_o,
  output logic [DATA_WIDTH-1:0]         data_rdata_o,
  output logic                          ram_en_o,
  output logic                          ram_we_o,
  output logic [DATA_WIDTH/8-1:0]       ram_be_o,
  output logic [RAM_ADDR_WIDTH-1:0]     ram_addr_o,
  output logic [DATA_WIDTH-1:0]         ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]         ram_rdata_i,
  output logic [CONFLICT_CNT_WIDTH-1:0] conflict_cnt_o
);

  // Handshake: a port holds req and its payload until gnt is high in the same
  // cycle. The RAM access happens in that cycle, and exactly one cycle later
  // rvalid is high on the same port with rdata taken from the RAM output.
  logic [1:0] req;
  logic [1:0] gnt;
  port_sel_e  arb_last;
  logic       rsp_valid_q;
  port_sel_e  rsp_sel_q;
  logic [CONFLICT_CNT_WIDTH-1:0] conflict_cnt_q;

  assign req = {data_req_i, instr_req_i};

  rr_arb2 u_rr_arb2 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    (req),
    .gnt    (gnt),
    .last_o (arb_last)
  );

  assign instr_gnt_o = gnt[0];
  assign data_gnt_o  = gnt[1];

  // Upper address bits are dropped, so out-of-range addresses wrap.
  always_comb begin
    ram_en_o    = |gnt;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (gnt[0]) begin
      ram_be_o   = '1;
      ram_addr_o = {instr_addr_i[RAM_ADDR_WIDTH-1:2], 2'b00};
    end else if (gnt[1]) begin
      ram_we_o    = data_we_i;
      ram_be_o    = data_be_i;
      ram_addr_o  = {data_addr_i[RAM_ADDR_WIDTH-1:2], 2'b00};
      ram_wdata_o = data_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_sel_q   <= PORT_INSTR;
    end else begin
      rsp_valid_q <= |gnt;
      rsp_sel_q   <= gnt[1] ? PORT_DATA : PORT_INSTR;
    end
  end

  assign instr_rvalid_o = rsp_valid_q && (rsp_sel_q == PORT_INSTR);
  assign data_rvalid_o  = rsp_valid_q && (rsp_sel_q == PORT_DATA);
  assign instr_rdata_o  = ram_rdata_i;
  assign data_rdata_o   = ram_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_q <= '0;
    end else if (instr_req_i && data_req_i && conflict_cnt_q != '1) begin
      conflict_cnt_q <= conflict_cnt_q + 1'b1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;

  logic unused_ok;
  assign unused_ok = ^{instr_addr_i[31:RAM_ADDR_WIDTH], instr_addr_i[1:0],
                       data_addr_i[31:RAM_ADDR_WIDTH], data_addr_i[1:0], arb_last};

endmodule
